// File: rtl/adc_align_ctrl.sv
// Training-pattern alignment controller: sweeps all lane delay taps, tracks the
// longest passing window per lane, then parks each lane at its window centre.
module adc_align_ctrl #(
  parameter int unsigned LANES         = 8,
  parameter int unsigned TAP_WIDTH     = 5,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CHECK_FRAMES  = 64,
  parameter int unsigned MIN_WINDOW    = 3,
  parameter logic [11:0] TRAIN_PATTERN = 12'hA72
) (
  input  logic                       dclk_neg,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       frame_en,
  input  logic [LANES*12-1:0]        lane_word,
  output logic                       dly_ld,
  output logic [LANES-1:0]           dly_ce,
  output logic                       dly_inc,
  output logic                       busy,
  output logic                       locked,
  output logic                       fail,
  output logic [LANES-1:0]           lane_err,
  output logic [LANES*TAP_WIDTH-1:0] tap_sel
);

  localparam int unsigned LW      = TAP_WIDTH + 1;
  localparam int unsigned TAP_MAX = (2 ** TAP_WIDTH) - 1;
  localparam int unsigned SW      = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned FW      = $clog2(CHECK_FRAMES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CHECK, S_EVAL, S_STEP,
    S_CENTER, S_RELOAD, S_APPLY, S_DONE, S_FAIL
  } state_t;

  state_t                 state;
  logic [TAP_WIDTH-1:0]   tap;
  logic [SW-1:0]          settle_cnt;
  logic [FW-1:0]          frame_cnt;
  logic [LW-1:0]          apply_k;
  logic [LANES-1:0]       bad;
  logic [TAP_WIDTH-1:0]   run_start  [LANES];
  logic [LW-1:0]          run_len    [LANES];
  logic [TAP_WIDTH-1:0]   best_start [LANES];
  logic [LW-1:0]          best_len   [LANES];
  logic [TAP_WIDTH-1:0]   target     [LANES];

  logic [TAP_WIDTH-1:0]   nxt_start  [LANES];
  logic [LW-1:0]          nxt_len    [LANES];
  logic [TAP_WIDTH-1:0]   ctr_tgt    [LANES];
  logic [LANES-1:0]       word_bad;
  logic [LANES-1:0]       too_short;
  logic [LANES-1:0]       tgt_nz;
  logic [LANES-1:0]       ce_next;
  logic [LANES*TAP_WIDTH-1:0] tgt_flat;
  logic [TAP_WIDTH-1:0]   max_tgt;
  logic [LW-1:0]          k_nxt;

  assign k_nxt = apply_k + LW'(1);

  always_comb begin
    max_tgt  = '0;
    tgt_flat = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      word_bad[i]  = (lane_word[12*i +: 12] != TRAIN_PATTERN);
      nxt_len[i]   = bad[i] ? '0 : ((run_len[i] == '0) ? LW'(1) : run_len[i] + LW'(1));
      nxt_start[i] = (!bad[i] && run_len[i] == '0) ? tap : run_start[i];
      ctr_tgt[i]   = TAP_WIDTH'(LW'(best_start[i]) + (best_len[i] >> 1));
      too_short[i] = (best_len[i] < LW'(MIN_WINDOW));
      tgt_nz[i]    = (target[i] != '0);
      ce_next[i]   = (LW'(target[i]) > k_nxt);
      tgt_flat[TAP_WIDTH*i +: TAP_WIDTH] = target[i];
      if (target[i] > max_tgt) max_tgt = target[i];
    end
  end

  always_ff @(posedge dclk_neg) begin
    if (!resetn) begin
      state      <= S_IDLE;
      tap        <= '0;
      settle_cnt <= '0;
      frame_cnt  <= '0;
      apply_k    <= '0;
      bad        <= '0;
      dly_ld     <= 1'b0;
      dly_ce     <= '0;
      dly_inc    <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      fail       <= 1'b0;
      lane_err   <= '0;
      tap_sel    <= '0;
      for (int unsigned i = 0; i < LANES; i++) begin
        run_start[i]  <= '0;
        run_len[i]    <= '0;
        best_start[i] <= '0;
        best_len[i]   <= '0;
        target[i]     <= '0;
      end
    end else begin
      // Delay controls default low so every pulse is exactly one cycle wide.
      dly_ld  <= 1'b0;
      dly_ce  <= '0;
      dly_inc <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            locked   <= 1'b0;
            fail     <= 1'b0;
            lane_err <= '0;
            tap_sel  <= '0;
            busy     <= 1'b1;
            tap      <= '0;
            bad      <= '0;
            dly_ld   <= 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
              run_start[i]  <= '0;
              run_len[i]    <= '0;
              best_start[i] <= '0;
              best_len[i]   <= '0;
            end
            state <= S_LOAD;
          end
        end
        S_LOAD, S_STEP: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            frame_cnt <= '0;
            state     <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_CHECK: begin
          if (frame_en) begin
            bad <= bad | word_bad;
            if (frame_cnt == FW'(CHECK_FRAMES - 1)) state <= S_EVAL;
            else frame_cnt <= frame_cnt + FW'(1);
          end
        end
        S_EVAL: begin
          for (int unsigned i = 0; i < LANES; i++) begin
            run_len[i]   <= nxt_len[i];
            run_start[i] <= nxt_start[i];
            if (nxt_len[i] > best_len[i]) begin
              best_len[i]   <= nxt_len[i];
              best_start[i] <= nxt_start[i];
            end
          end
          bad <= '0;
          if (tap == TAP_WIDTH'(TAP_MAX)) begin
            state <= S_CENTER;
          end else begin
            tap     <= tap + TAP_WIDTH'(1);
            dly_ce  <= '1;
            dly_inc <= 1'b1;
            state   <= S_STEP;
          end
        end
        S_CENTER: begin
          target   <= ctr_tgt;
          lane_err <= too_short;
          if (|too_short) begin
            fail  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            dly_ld <= 1'b1;
            state  <= S_RELOAD;
          end
        end
        S_RELOAD: begin
          // Pulse for k=0 is issued here so APPLY sees one pulse per cycle it lasts.
          apply_k <= '0;
          dly_ce  <= tgt_nz;
          dly_inc <= |tgt_nz;
          state   <= S_APPLY;
        end
        S_APPLY: begin
          if (k_nxt >= LW'(max_tgt)) begin
            tap_sel <= tgt_flat;
            locked  <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
          end else begin
            apply_k <= k_nxt;
            dly_ce  <= ce_next;
            dly_inc <= |ce_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Scoreboard bench for adc_align_ctrl: models lane delay lines and per-tap
// pattern validity, predicts window centres and checks pulses and results.
module tb_adc_align_ctrl;

  localparam int unsigned LANES = 8;
  localparam int unsigned TW    = 5;
  localparam int unsigned NT    = 32;
  localparam logic [11:0] PAT   = 12'hA72;

  logic                  dclk_neg = 1'b0;
  logic                  resetn   = 1'b0;
  logic                  start    = 1'b0;
  logic                  frame_en = 1'b0;
  logic [LANES*12-1:0]   lane_word = '0;
  logic                  dly_ld;
  logic [LANES-1:0]      dly_ce;
  logic                  dly_inc;
  logic                  busy;
  logic                  locked;
  logic                  fail;
  logic [LANES-1:0]      lane_err;
  logic [LANES*TW-1:0]   tap_sel;

  always #5 dclk_neg = ~dclk_neg;

  adc_align_ctrl #(
    .LANES(LANES), .TAP_WIDTH(TW), .SETTLE_CYCLES(16), .CHECK_FRAMES(64),
    .MIN_WINDOW(3), .TRAIN_PATTERN(PAT)
  ) dut (
    .dclk_neg(dclk_neg), .resetn(resetn), .start(start), .frame_en(frame_en),
    .lane_word(lane_word), .dly_ld(dly_ld), .dly_ce(dly_ce), .dly_inc(dly_inc),
    .busy(busy), .locked(locked), .fail(fail), .lane_err(lane_err), .tap_sel(tap_sel)
  );

  typedef struct {
    logic                locked;
    logic                fail;
    logic [LANES-1:0]    lane_err;
    logic [LANES*TW-1:0] tap_sel;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] pass_mask [LANES];
  int          corrupt_lane = -1;
  int          corrupt_tap  = 0;
  int          tap_m  [LANES];
  int          since  [LANES];
  int          ce_cnt [LANES];
  int          ld_cnt   = 0;
  int          viol_cnt = 0;
  int          errors   = 0;
  int          checks   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] win(input int unsigned lo, input int unsigned hi);
    logic [31:0] w = '0;
    for (int unsigned t = lo; t <= hi; t++) w[t] = 1'b1;
    return w;
  endfunction

  function automatic exp_t model();
    exp_t e;
    e.lane_err = '0;
    e.tap_sel  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [31:0] m = pass_mask[i];
      int unsigned best_s = 0, best_l = 0;
      if (int'(i) == corrupt_lane) m[corrupt_tap] = 1'b0;
      for (int unsigned s = 0; s < NT; s++) begin
        bool_start: begin
          logic opens;
          if (s == 0) opens = m[s];
          else        opens = m[s] && !m[s-1];
          if (opens) begin
            int unsigned l = 0;
            while (s + l < NT && m[s+l]) l++;
            if (l > best_l) begin best_l = l; best_s = s; end
          end
        end
      end
      e.lane_err[i] = (best_l < 3);
      e.tap_sel[TW*i +: TW] = TW'(best_s + best_l / 2);
    end
    e.fail   = |e.lane_err;
    e.locked = !e.fail;
    if (e.fail) e.tap_sel = '0;
    return e;
  endfunction

  // Delay-line and ADC model: settling garbage after any tap change, then the
  // training pattern only where the lane's mask passes at its current tap.
  initial begin
    logic [11:0] w;
    logic        good;
    for (int unsigned i = 0; i < LANES; i++) begin
      tap_m[i] = 0; since[i] = 100; ce_cnt[i] = 0; pass_mask[i] = '0;
    end
    forever begin
      @(negedge dclk_neg);
      if (dly_ld && dly_ce != '0) viol_cnt++;
      if (dly_ce != '0 && !dly_inc) viol_cnt++;
      if (dly_ld) ld_cnt++;
      frame_en = ($urandom_range(0, 4) != 0);
      for (int unsigned i = 0; i < LANES; i++) begin
        if (dly_ld) begin
          tap_m[i] = 0; since[i] = 0;
        end else if (dly_ce[i]) begin
          tap_m[i]++; since[i] = 0; ce_cnt[i]++;
        end else if (since[i] < 1000) begin
          since[i]++;
        end
        good = (tap_m[i] < int'(NT)) && pass_mask[i][tap_m[i] % NT] && since[i] >= 12;
        if (int'(i) == corrupt_lane && tap_m[i] == corrupt_tap && since[i] == 40) begin
          good = 1'b0; frame_en = 1'b1;
        end
        w = PAT;
        if (!good) w = PAT ^ 12'($urandom_range(1, 4095));
        lane_word[12*i +: 12] = w;
      end
    end
  end

  task automatic run_align(input string name, input int restart_at);
    exp_t e;
    int   ld0, v0, n, exp_ce;
    int   ce0 [LANES];
    sb_q.push_back(model());
    ld0 = ld_cnt;
    v0  = viol_cnt;
    for (int unsigned i = 0; i < LANES; i++) ce0[i] = ce_cnt[i];
    @(negedge dclk_neg); start = 1'b1;
    @(negedge dclk_neg); start = 1'b0;
    check($sformatf("%s:start_resp", name), {busy, locked, fail, dly_ld}, 4'b1001);
    n = 0;
    while (busy && n < 20000) begin
      @(negedge dclk_neg);
      n++;
      start = (n == restart_at);
    end
    start = 1'b0;
    check($sformatf("%s:done_in_time", name), busy, 1'b0);
    repeat (3) @(negedge dclk_neg);
    e = sb_q.pop_front();
    check($sformatf("%s:locked", name), locked, e.locked);
    check($sformatf("%s:fail", name), fail, e.fail);
    check($sformatf("%s:lane_err", name), lane_err, e.lane_err);
    check($sformatf("%s:tap_sel", name), tap_sel, e.tap_sel);
    check($sformatf("%s:ld_pulses", name), ld_cnt - ld0, e.locked ? 2 : 1);
    check($sformatf("%s:pulse_rules", name), viol_cnt - v0, 0);
    for (int unsigned i = 0; i < LANES; i++) begin
      exp_ce = 31 + (e.locked ? int'(e.tap_sel[TW*i +: TW]) : 0);
      check($sformatf("%s:ce_pulses[%0d]", name, i), ce_cnt[i] - ce0[i], exp_ce);
      if (e.locked)
        check($sformatf("%s:final_dly[%0d]", name, i), tap_m[i], e.tap_sel[TW*i +: TW]);
    end
  endtask

  task automatic set_all(input logic [31:0] m);
    for (int unsigned i = 0; i < LANES; i++) pass_mask[i] = m;
  endtask

  initial begin
    int ce_sum0, ce_sum1;
    set_all(win(8, 20));
    repeat (3) @(negedge dclk_neg);
    check("reset_outputs", {busy, locked, fail, lane_err, tap_sel, dly_ld, dly_ce, dly_inc}, '0);
    resetn = 1'b1;
    @(negedge dclk_neg);

    run_align("all_8_20", 0);

    pass_mask[3] = '0;
    run_align("lane3_dead", 0);

    set_all(win(8, 20));
    pass_mask[0] = win(2, 5) | win(20, 29);
    run_align("lane0_two_win", 0);

    set_all(win(8, 20));
    pass_mask[1] = win(25, 31);
    pass_mask[4] = win(4, 7) | win(12, 15);
    run_align("top_edge_tie", 0);

    set_all(win(8, 20));
    corrupt_lane = 2;
    corrupt_tap  = 12;
    run_align("corrupt_restart", 700);
    corrupt_lane = -1;

    @(negedge dclk_neg); start = 1'b1;
    @(negedge dclk_neg); start = 1'b0;
    repeat (600) @(negedge dclk_neg);
    check("midscan_busy", busy, 1'b1);
    resetn = 1'b0;
    @(negedge dclk_neg);
    check("midscan_reset", {busy, locked, fail, lane_err, tap_sel, dly_ld, dly_ce, dly_inc}, '0);
    ce_sum0 = 0;
    for (int unsigned i = 0; i < LANES; i++) ce_sum0 += ce_cnt[i];
    resetn = 1'b1;
    repeat (20) @(negedge dclk_neg);
    ce_sum1 = 0;
    for (int unsigned i = 0; i < LANES; i++) ce_sum1 += ce_cnt[i];
    check("post_reset_no_ce", ce_sum1 - ce_sum0, 0);
    check("post_reset_idle", {busy, locked, fail}, 3'b000);

    for (int unsigned i = 0; i < LANES; i++) pass_mask[i] = win(i + 2, i + 12);
    run_align("after_reset", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_align_ctrl.md
# adc_align_ctrl

Training-pattern alignment controller for the ADC deserializer front end. It runs in the `dclk_neg` domain and sweeps the per-lane input delay taps from 0 to max. At each tap it checks every lane's 12-bit frame word against a fixed training pattern, then finds the longest passing window per lane. Finally it parks each lane's delay at the centre of that window and reports lock or failure to software.

## Interface
Parameters:
- LANES, 8, number of ADC data lanes.
- TAP_WIDTH, 5, delay tap counter width; taps run 0..2**TAP_WIDTH-1.
- SETTLE_CYCLES, 16, idle cycles after any tap change before checking.
- CHECK_FRAMES, 64, frame strobes evaluated per tap.
- MIN_WINDOW, 3, minimum passing-window length for lock.
- TRAIN_PATTERN, 12'hA72, expected word on every lane during training.

Ports:
- dclk_neg  in  1  clock; ADC bit-clock domain (negative dclk).
- resetn  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle request to begin alignment; ignored while busy.
- frame_en  in  1  one-cycle strobe; lane_word valid this cycle.
- lane_word  in  LANES*12  deserialized words, lane i at [12*i+:12].
- dly_ld  out  1  one-cycle pulse; all lane delays load tap 0.
- dly_ce  out  LANES  per-lane one-cycle increment enable.
- dly_inc  out  1  increment direction; constant 1 whenever dly_ce is nonzero.
- busy  out  1  high from start acceptance until DONE/FAIL.
- locked  out  1  alignment succeeded on all lanes.
- fail  out  1  at least one lane lacks a window of at least MIN_WINDOW.
- lane_err  out  LANES  lanes whose best window is shorter than MIN_WINDOW.
- tap_sel  out  LANES*TAP_WIDTH  final tap per lane, lane i at [TAP_WIDTH*i+:TAP_WIDTH].

## Operation
- Reset values: all outputs are 0 and the FSM is in IDLE.
- IDLE / DONE / FAIL accept start:
  - Clear locked, fail, lane_err, tap_sel, and the per-lane window trackers.
  - Set tap=0 and go to LOAD.
- LOAD: dly_ld=1 for 1 cycle, then SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then CHECK.
  - frame_en is ignored.
- CHECK:
  - Count CHECK_FRAMES frame_en strobes.
  - For each strobe, set a per-lane bad flag if lane_word[i] != TRAIN_PATTERN.
  - The cycle after the last strobe, go to EVAL.
- EVAL (1 cycle), per lane:
  - Pass (bad=0): if no run is open, set run_start=tap and run_len=1; otherwise run_len++.
  - Fail: close the run (run_len=0).
  - Whenever run_len after update > best_len, set best_start=run_start and best_len=run_len.
  - Strictly greater: on a tie the earlier window wins.
  - Clear the bad flags.
  - If tap == max, go to CENTER. Otherwise go to STEP.
- STEP: dly_ce=all-ones, dly_inc=1 for 1 cycle, tap++, then SETTLE.
- CENTER (1 cycle):
  - target[i] = best_start[i] + (best_len[i] >> 1), TAP_WIDTH bits, no overflow possible.
  - lane_err[i] = (best_len[i] < MIN_WINDOW).
  - If lane_err is nonzero, go to FAIL. Otherwise go to RELOAD.
- RELOAD: dly_ld pulse, then APPLY with k=0.
- APPLY: each cycle, dly_ce[i] = (target[i] > k), then k++.
  - When k reaches the maximum target, set tap_sel=target and go to DONE.
  - If every target is 0, go to DONE after one cycle with dly_ce=0.
- DONE: locked=1, busy=0.
- FAIL: fail=1, busy=0, lane_err holds, dly_* idle.
- Counter widths:
  - run_len and best_len are TAP_WIDTH+1 bits, so a window spanning all taps fits.
  - The frame counter is sized to CHECK_FRAMES.

## Timing
- start sampled high in IDLE/DONE/FAIL: busy=1 and locked=fail=0 the next cycle. dly_ld is asserted in that same cycle.
- start while busy: no effect.
- dly_ld and each dly_ce are exactly one cycle wide. They are never asserted together.
- Minimum time per tap: 1 (LOAD/STEP) + SETTLE_CYCLES + CHECK duration + 1 (EVAL).
- A frame_en arriving in the EVAL or STEP cycle is not counted.
- A run open at the last tap is finalised in that tap's EVAL; windows touching tap max are valid.
- resetn low mid-operation: on the next edge all outputs return to reset values and no further dly_ce is issued. Delay primitives are left as-is; the next start reloads them.
- locked, fail and tap_sel are stable until the next accepted start or reset.

## Test plan
- Every lane passes at taps 8..20 only:
  - tap_sel=14 on every lane, locked=1, fail=0.
  - Exactly one dly_ld in the scan phase and 31 STEP pulses, then one RELOAD dly_ld and 14 dly_ce pulses per lane.
- Lane 3 never matches; other lanes pass at 8..20: fail=1, lane_err=8'h08, locked=0, no APPLY pulses.
- Lane 0 passes at 2..5 and 20..29; other lanes pass at 8..20: lane 0 tap_sel=25, locked=1.
- Lane 1 passes at 25..31 (window at the top edge) → tap_sel=28. Equal windows 4..7 and 12..15 → earlier window, tap_sel=6.
- One corrupted frame out of 64 at tap 12 inside window 8..20 on lane 2 → best window is 13..20, tap_sel=17.
- start pulsed mid-scan → ignored. resetn low mid-scan → all outputs 0 next cycle. A new start then completes a normal alignment.
